// File: rtl/mmio_ctrl.sv
// Memory-mapped CPU read/write controller: BIOS/DMEM/I/O read mux, UART RX/TX FIFOs,
// cycle and retired-instruction counters.
module mmio_ctrl #(
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned CNT_W    = 32,
    parameter logic [3:0]  BIOS_SEL = 4'h4,
    parameter logic [3:0]  IO_SEL   = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] bios_doutb,
    input  logic [31:0] dmem_douta,
    output logic [31:0] dout,
    input  logic        inst_ret,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_CW = RX_AW + 1;
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam logic [RX_AW:0] RX_MAX = RX_CW'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_MAX = TX_CW'(TX_DEPTH);

    typedef enum logic [1:0] {SEL_DMEM, SEL_BIOS, SEL_IO} src_sel_e;

    src_sel_e    sel_q, sel_d;
    logic        rd_q;
    logic [31:0] io_hold, io_rdata;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_ovf;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;

    logic [CNT_W-1:0] cyc_cnt, ret_cnt;

    logic       is_io, io_rd, io_wr;
    logic [7:0] reg_off;
    logic       rx_pop, rx_acc, cnt_clr, tx_pop, tx_acc;
    logic       unused_bits;

    assign unused_bits = &{1'b0, addr[27:8], wdata[31:8]};

    assign is_io   = (addr[31:28] == IO_SEL);
    assign reg_off = addr[7:0];
    assign io_rd   = re && is_io;
    assign io_wr   = we && is_io;
    assign rx_pop  = io_rd && (reg_off == 8'h04) && (rx_count != '0);
    assign rx_acc  = rx_valid && ((rx_count < RX_MAX) || rx_pop);
    assign cnt_clr = io_wr && (reg_off == 8'h18);
    assign tx_pop  = tx_valid && tx_ready;
    assign tx_acc  = io_wr && (reg_off == 8'h08) && ((tx_count < TX_MAX) || tx_pop);

    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : '0;

    always_comb begin
        sel_d = SEL_DMEM;
        if (addr[31:28] == BIOS_SEL)
            sel_d = SEL_BIOS;
        else if (addr[31:28] == IO_SEL)
            sel_d = SEL_IO;
    end

    always_comb begin
        io_rdata = '0;
        case (reg_off)
            8'h00: io_rdata = {29'b0, rx_ovf, rx_count != '0, tx_count != TX_MAX};
            8'h04: if (rx_count != '0) io_rdata = {24'b0, rx_mem[rx_rd_ptr]};
            8'h10: io_rdata = 32'(cyc_cnt);
            8'h14: io_rdata = 32'(ret_cnt);
            8'h1C: io_rdata = {7'b0, 9'(tx_count), 7'b0, 9'(rx_count)};
            default: io_rdata = '0;
        endcase
    end

    // Memory data arrives a cycle after addr, so only the source choice is registered.
    always_comb begin
        dout = '0;
        if (rd_q) begin
            case (sel_q)
                SEL_BIOS: dout = bios_doutb;
                SEL_IO:   dout = io_hold;
                default:  dout = dmem_douta;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= SEL_DMEM;
            rd_q    <= 1'b0;
            io_hold <= '0;
        end else begin
            rd_q <= re;
            if (re)
                sel_q <= sel_d;
            if (io_rd)
                io_hold <= io_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_acc)
            rx_mem[rx_wr_ptr] <= rx_data;
        if (tx_acc)
            tx_mem[tx_wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            if (rx_acc)
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_acc && !rx_pop)
                rx_count <= rx_count + RX_CW'(1);
            else if (!rx_acc && rx_pop)
                rx_count <= rx_count - RX_CW'(1);
            if (cnt_clr)
                rx_ovf <= 1'b0;
            else if (rx_valid && !rx_acc)
                rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_acc)
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_acc && !tx_pop)
                tx_count <= tx_count + TX_CW'(1);
            else if (!tx_acc && tx_pop)
                tx_count <= tx_count - TX_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (inst_ret)
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: default instance plus a CNT_W=4 instance for counter wrap.
module tb_mmio_ctrl;

    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RXD  = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_RET  = 32'h8000_0014;
    localparam logic [31:0] A_CLR  = 32'h8000_0018;
    localparam logic [31:0] A_LVL  = 32'h8000_001C;
    localparam logic [31:0] BIOS_V = 32'hB105_0001;
    localparam logic [31:0] DMEM_V = 32'hD0E0_0002;

    logic        clk = 1'b0;
    logic        rst_n, re, we, inst_ret, rx_valid, tx_ready;
    logic [31:0] addr, wdata, bios_doutb, dmem_douta, dout, dout4;
    logic [7:0]  rx_data, tx_data, tx_data4;
    logic        tx_valid, tx_valid4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
        .bios_doutb(bios_doutb), .dmem_douta(dmem_douta), .dout(dout),
        .inst_ret(inst_ret), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    mmio_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
        .bios_doutb(bios_doutb), .dmem_douta(dmem_douta), .dout(dout4),
        .inst_ret(inst_ret), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; inst_ret = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        addr = '0; wdata = '0; rx_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        re = 1'b1;
        tick();
        re = 1'b0;
        check_eq(tag, dout, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        bios_doutb = BIOS_V;
        dmem_douta = DMEM_V;
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; inst_ret = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        addr = '0; wdata = '0; rx_data = '0;
        #12;
        check_eq("rst_dout", dout, 32'h0);
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);

        // status, RX path
        do_reset();
        rd(A_STAT, 32'h1, "status_rst");
        rd(A_LVL, 32'h0, "levels_rst");
        push(8'h41);
        push(8'h42);
        rd(A_LVL, 32'h2, "levels_rx2");
        rd(A_STAT, 32'h3, "status_rx");
        rd(A_RXD, 32'h41, "rx_first");
        rd(A_RXD, 32'h42, "rx_second");
        rd(A_RXD, 32'h0, "rx_empty");
        rd(A_STAT, 32'h1, "status_rx_drained");

        // RX overflow and clear
        for (int i = 0; i < 9; i++)
            push(8'(8'h10 + i));
        rd(A_LVL, 32'h8, "levels_rx_full");
        rd(A_STAT, 32'h7, "status_ovf");
        wr(A_CLR, 32'h0);
        rd(A_STAT, 32'h3, "status_ovf_clr");
        rd(A_RXD, 32'h10, "rx_head_after_ovf");
        push(8'h20);
        addr = A_RXD; re = 1'b1; rx_data = 8'h21; rx_valid = 1'b1;
        tick();
        re = 1'b0; rx_valid = 1'b0;
        check_eq("rx_push_pop_full", dout, 32'h11);
        rd(A_LVL, 32'h8, "levels_push_pop");
        rd(A_STAT, 32'h3, "status_no_ovf");

        // write decode, re+we together
        do_reset();
        wr(32'h0000_0008, 32'hAA);
        rd(A_LVL, 32'h0, "wr_outside_io");
        addr = A_TXD; wdata = 32'h55; re = 1'b1; we = 1'b1;
        tick();
        re = 1'b0; we = 1'b0;
        check_eq("rw_same_dout", dout, 32'h0);
        rd(A_LVL, 32'h0001_0000, "rw_same_levels");
        check_eq("tx_single", {24'b0, tx_data}, 32'h55);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("tx_single_gone", {31'b0, tx_valid}, 32'h0);

        // TX fill, drop, drain
        for (int i = 0; i < 9; i++)
            wr(A_TXD, 32'(i));
        rd(A_LVL, 32'h0008_0000, "levels_tx_full");
        rd(A_STAT, 32'h0, "status_tx_full");
        tick();
        tick();
        check_eq("tx_stall_valid", {31'b0, tx_valid}, 32'h1);
        check_eq("tx_stall_data", {24'b0, tx_data}, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("tx_drain_valid", {31'b0, tx_valid}, 32'h1);
            check_eq("tx_drain_data", {24'b0, tx_data}, 32'(i));
            tick();
        end
        check_eq("tx_drained", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // counters: first edge after release is edge 1
        do_reset();
        repeat (10) tick();
        inst_ret = 1'b1;
        repeat (3) tick();
        inst_ret = 1'b0;
        rd(A_CYC, 32'd13, "cycle_cnt");
        check_eq("cycle_cnt_w4", dout4, 32'd13);
        rd(A_RET, 32'd3, "instret_cnt");
        check_eq("instret_cnt_w4", dout4, 32'd3);
        rd(A_CYC, 32'd15, "cycle_15");
        check_eq("cycle_15_w4", dout4, 32'd15);
        rd(A_CYC, 32'd16, "cycle_16");
        check_eq("cycle_wrap_w4", dout4, 32'd0);
        wr(A_CLR, 32'h0);
        rd(A_CYC, 32'd0, "cycle_after_clr");
        rd(A_RET, 32'd0, "instret_after_clr");

        // back-to-back source select
        addr = 32'h4000_0000; re = 1'b1;
        tick();
        check_eq("b2b_bios", dout, BIOS_V);
        addr = 32'h0000_1000;
        tick();
        check_eq("b2b_dmem", dout, DMEM_V);
        addr = A_STAT;
        tick();
        check_eq("b2b_status", dout, 32'h1);
        re = 1'b0;
        tick();
        check_eq("idle_dout", dout, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter RX_DEPTH, default 8, RX FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter TX_DEPTH, default 8, TX FIFO entries; SHALL be a power of two, 2..256.
REQ-003 Parameter CNT_W, default 32, counter width; SHALL be 1..32, zero-extended to 32 on read.
REQ-004 Parameter BIOS_SEL, default 4'h4, addr[31:28] value selecting BIOS.
REQ-005 Parameter IO_SEL, default 4'h8, addr[31:28] value selecting I/O.
REQ-006 Ports, in order: clk in 1, sole clock, rising edge; rst_n in 1, asynchronous active-low reset.
REQ-007 addr in 32, CPU byte address; re in 1, read request; we in 1, write request; wdata in 32, write data.
REQ-008 bios_doutb in 32, dmem_douta in 32: synchronous-memory read data, valid one cycle after addr.
REQ-009 dout out 32, registered read data.
REQ-010 inst_ret in 1, one-cycle pulse per retired instruction.
REQ-011 rx_data in 8 and rx_valid in 1: UART receiver byte plus one-cycle strobe.
REQ-012 tx_data out 8, tx_valid out 1, tx_ready in 1: valid/ready byte stream to the UART transmitter.

Function
REQ-013 Read latency SHALL be one cycle: dout in cycle N+1 reflects addr and re sampled at edge N.
REQ-014 Source select: addr[31:28]==BIOS_SEL -> bios_doutb; ==IO_SEL -> I/O register; otherwise dmem_douta. Select SHALL be registered at N; memory data SHALL pass combinationally in N+1.
REQ-015 I/O read value SHALL be captured at edge N into a holding register.
REQ-016 I/O map, addr[7:0]: 0x00 status R; 0x04 RX data R; 0x08 TX data W; 0x10 cycle count R; 0x14 instret count R; 0x18 counter reset W; 0x1C levels R.
REQ-017 Unmapped I/O reads SHALL return 0. Unmapped I/O writes, and any write outside IO_SEL, SHALL be ignored.
REQ-018 Status SHALL be {29'b0, rx_ovf, ~rx_empty, ~tx_full}.
REQ-019 Levels SHALL be {7'b0, tx_count[8:0], 7'b0, rx_count[8:0]}.
REQ-020 An RX data read with RX non-empty SHALL return {24'b0, head} and pop one entry. With RX empty it SHALL return 0 and not pop.
REQ-021 RX push on rx_valid SHALL be accepted when rx_count<RX_DEPTH or a pop occurs the same cycle. Otherwise the byte SHALL be dropped and rx_ovf set.
REQ-022 Simultaneous RX push and pop SHALL leave rx_count unchanged. With RX empty, only the push takes effect.
REQ-023 A TX write SHALL push wdata[7:0] when tx_count<TX_DEPTH or a tx pop occurs the same cycle; otherwise the byte SHALL be dropped silently.
REQ-024 TX outputs: tx_valid = (tx_count!=0); tx_data = TX head, driven from register state.
REQ-025 TX pop SHALL occur when tx_valid && tx_ready. tx_data SHALL stay stable while tx_valid && !tx_ready.
REQ-026 FIFO pointers SHALL wrap modulo depth; counts SHALL span 0..DEPTH inclusive.
REQ-027 Cycle counter SHALL increment every cycle. Instret counter SHALL increment on inst_ret. Both SHALL wrap modulo 2^CNT_W.
REQ-028 A write to 0x18 SHALL zero both counters and clear rx_ovf at that edge, overriding same-cycle increment and overflow.
REQ-029 re and we in the same cycle SHALL both be performed.
REQ-030 The block SHALL contain no combinational path from tx_ready to tx_valid, or from re/addr to dout.

Reset
REQ-031 While rst_n is low, asynchronously: dout=0; tx_valid=0; tx_data=0; FIFOs empty; counts 0; both counters 0; rx_ovf=0; registered select = dmem.
REQ-032 Reset mid-transfer SHALL discard all FIFO contents. The first rising edge with rst_n high SHALL resume normal operation.

Verification
REQ-033 Reset, then re at 0x80000000 -> next-cycle dout=0x00000001 (TX not full, RX empty, no overflow).
REQ-034 Pulse rx_valid with 0x41 then 0x42, read 0x80000004 twice -> dout 0x41 then 0x42. Third read -> 0x0; status bit1=0.
REQ-035 RX_DEPTH=8: push 9 bytes with no reads -> levels rx_count=8, status=0x00000007. Write 0x80000018 -> status=0x00000003.
REQ-036 tx_ready=0, write 9 bytes 0x00..0x08 to 0x80000008 (TX_DEPTH=8) -> tx_count=8, tx_data=0x00 stable. Raise tx_ready -> bytes 0x00..0x07 emitted on consecutive cycles, then tx_valid=0.
REQ-037 Reset, 10 idle cycles, 3 inst_ret pulses, read 0x80000010 and 0x80000014 -> cycle value equals edge count since reset, instret=3. CNT_W=4 -> cycle count wraps 15->0.
REQ-038 Back-to-back reads 0x40000000, 0x00001000, 0x80000000 -> dout shows bios_doutb, dmem_douta, status in consecutive cycles.
